// File: rtl/button_event_ctrl.sv
// Debounced push-button Avalon-MM slave: level, W1C press/release capture,
// press counter and a maskable level interrupt for the Nios.
module button_event_ctrl #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic        in_port,
   output logic        irq
);

   typedef enum logic [1:0] {ST_LOW, WAIT_HIGH, ST_HIGH, WAIT_LOW} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       sync_q;
   logic             s;
   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db;
   logic             press_ev, rel_ev;
   logic             wr_en;
   logic [1:0]       irqmask_q, irqmask_d;
   logic [1:0]       edgecap_q, edgecap_d;
   logic [7:0]       presscnt_q, presscnt_d;
   logic [31:0]      readdata_d;
   logic             unused_wdata;

   assign unused_wdata = ^writedata[31:2];

   // Two-flop synchronizer for the asynchronous pin
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) sync_q <= 2'b00;
      else          sync_q <= {sync_q[0], in_port};
   end
   assign s = sync_q[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_LOW: begin
            if (s) begin
               state_d = WAIT_HIGH;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_HIGH: begin
            if (!s) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ST_HIGH: begin
            if (!s) begin
               state_d = WAIT_LOW;
               cnt_d   = CNT_ONE;
            end else begin
               cnt_d = '0;
            end
         end
         WAIT_LOW: begin
            if (s) begin
               state_d = ST_HIGH;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LOW;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = ST_LOW;
            cnt_d   = '0;
         end
      endcase
   end

   assign db       = (state_q == ST_HIGH) || (state_q == WAIT_LOW);
   assign press_ev = (state_d == ST_HIGH) && !db;
   assign rel_ev   = (state_d == ST_LOW)  && db;
   assign wr_en    = chipselect & write;

   // Event set is applied after the W1C clear so a coincident event survives
   always_comb begin
      irqmask_d  = irqmask_q;
      edgecap_d  = edgecap_q;
      presscnt_d = presscnt_q;
      if (wr_en && address == 2'd1) irqmask_d = writedata[1:0];
      if (wr_en && address == 2'd2) edgecap_d = edgecap_q & ~writedata[1:0];
      edgecap_d = edgecap_d | {rel_ev, press_ev};
      if (wr_en && address == 2'd3) presscnt_d = 8'd0;
      if (press_ev) presscnt_d = presscnt_d + 8'd1;
   end

   always_comb begin
      readdata_d = 32'd0;
      case (address)
         2'd0: readdata_d = {31'd0, db};
         2'd1: readdata_d = {30'd0, irqmask_q};
         2'd2: readdata_d = {30'd0, edgecap_q};
         2'd3: readdata_d = {24'd0, presscnt_q};
         default: readdata_d = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask_q  <= 2'b00;
         edgecap_q  <= 2'b00;
         presscnt_q <= 8'd0;
         readdata   <= 32'd0;
      end else begin
         irqmask_q  <= irqmask_d;
         edgecap_q  <= edgecap_d;
         presscnt_q <= presscnt_d;
         readdata   <= readdata_d;
      end
   end

   assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with DEBOUNCE_CYCLES=4; expected
// values are hand-derived edge counts from the pin change.
module tb_button_event_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        in_port = 1'b0;
   logic        irq;

   int checks = 0;
   int failures = 0;
   logic [31:0] v;

   always #5 clk = ~clk;

   button_event_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write      (write),
      .writedata  (writedata),
      .readdata   (readdata),
      .in_port    (in_port),
      .irq        (irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s got=0x%08h", tag, got);
      end
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      tick();
      d = readdata;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      tick();
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic settle();
      repeat (10) tick();
   endtask

   task automatic press_release();
      in_port = 1'b1;
      repeat (8) tick();
      in_port = 1'b0;
      repeat (8) tick();
   endtask

   initial begin
      // Reset held with the button pressed
      reset_n = 1'b0;
      in_port = 1'b1;
      repeat (3) tick();
      check("rst_rdata", readdata, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      address = 2'd2;
      tick();
      check("rst_rdata_a2", readdata, 32'd0);
      address = 2'd0;
      reset_n = 1'b1;
      repeat (6) tick();
      check("rst_db_before_e6", readdata, 32'd0);
      tick();
      check("rst_db_at_e6", readdata, 32'd1);
      rd(2'd2, v); check("rst_edgecap", v, 32'd1);
      rd(2'd3, v); check("rst_presscnt", v, 32'd1);
      in_port = 1'b0;
      settle();
      wr(2'd2, 32'd3);
      wr(2'd3, 32'd0);
      rd(2'd2, v); check("clr_edgecap", v, 32'd0);
      rd(2'd3, v); check("clr_presscnt", v, 32'd0);

      // Glitch rejection: 3 cycles high is too short
      address = 2'd0;
      in_port = 1'b1;
      repeat (3) tick();
      in_port = 1'b0;
      settle();
      rd(2'd0, v); check("glitch3_db", v, 32'd0);
      rd(2'd2, v); check("glitch3_edgecap", v, 32'd0);
      rd(2'd3, v); check("glitch3_presscnt", v, 32'd0);

      // 6 cycles high is accepted at edge 6
      address = 2'd0;
      in_port = 1'b1;
      repeat (6) tick();
      check("pulse6_db_before_e6", readdata, 32'd0);
      in_port = 1'b0;
      tick();
      check("pulse6_db_at_e6", readdata, 32'd1);
      rd(2'd2, v); check("pulse6_edgecap", v, 32'd1);
      settle();
      wr(2'd2, 32'd3);
      wr(2'd3, 32'd0);

      // Interrupt path
      wr(2'd1, 32'd1);
      rd(2'd1, v); check("irqmask_rb", v, 32'd1);
      address = 2'd0;
      in_port = 1'b1;
      repeat (5) tick();
      check("irq_before_e6", {31'd0, irq}, 32'd0);
      tick();
      check("irq_at_e6", {31'd0, irq}, 32'd1);
      repeat (4) tick();
      rd(2'd2, v); check("irq_edgecap", v, 32'd1);
      wr(2'd2, 32'd1);
      check("irq_after_w1c", {31'd0, irq}, 32'd0);
      in_port = 1'b0;
      settle();
      rd(2'd2, v); check("release_edgecap", v, 32'd2);
      check("release_irq_masked", {31'd0, irq}, 32'd0);

      // W1C write on the same edge as the press event
      wr(2'd2, 32'd3);
      address = 2'd0;
      in_port = 1'b1;
      repeat (5) tick();
      wr(2'd2, 32'd1);
      check("collide_irq", {31'd0, irq}, 32'd1);
      rd(2'd2, v); check("collide_edgecap", v, 32'd1);
      in_port = 1'b0;
      settle();
      wr(2'd2, 32'd3);
      wr(2'd1, 32'd0);
      wr(2'd3, 32'd0);

      // Press counter wrap
      repeat (255) press_release();
      rd(2'd3, v); check("cnt_255", v, 32'd255);
      press_release();
      rd(2'd3, v); check("cnt_wrap", v, 32'd0);
      repeat (3) press_release();
      rd(2'd3, v); check("cnt_3", v, 32'd3);
      in_port = 1'b1;
      repeat (5) tick();
      wr(2'd3, 32'd0);
      rd(2'd3, v); check("cnt_clr_collide", v, 32'd1);
      in_port = 1'b0;
      settle();

      // Asynchronous reset while WAIT_HIGH with counter=2
      wr(2'd1, 32'd3);
      check("pre_rst_irq", {31'd0, irq}, 32'd1);
      address = 2'd1;
      in_port = 1'b1;
      repeat (4) tick();
      check("pre_rst_mask", readdata, 32'd3);
      reset_n = 1'b0;
      #1;
      check("async_rst_rdata", readdata, 32'd0);
      check("async_rst_irq", {31'd0, irq}, 32'd0);
      repeat (2) tick();
      reset_n = 1'b1;
      address = 2'd2;
      repeat (4) tick();
      check("post_rst_no_stale", readdata, 32'd0);
      repeat (5) tick();
      rd(2'd2, v); check("post_rst_edgecap", v, 32'd1);
      rd(2'd3, v); check("post_rst_presscnt", v, 32'd1);
      rd(2'd1, v); check("post_rst_irqmask", v, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
